// File: rtl/mem_lsu.sv
// Load/store unit between the MEM pipeline stage and a single-beat memory bus.
// Optional bus-wait abort is enabled by defining MEM_LSU_TIMEOUT_EN.
module mem_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_lsu_valid_i,
  input  logic        mem_lsu_we_i,
  input  logic [63:0] mem_lsu_addr_i,
  input  logic [63:0] mem_lsu_wdata_i,
  input  logic [1:0]  mem_lsu_size_i,
  input  logic        mem_lsu_unsigned_i,
  output logic        mem_lsu_stall_o,
  output logic        mem_lsu_done_o,
  output logic        mem_lsu_err_o,
  output logic [63:0] mem_lsu_rdata_o,
  output logic        mem_lsu_bus_valid_o,
  output logic [1:0]  mem_lsu_bus_req_o,
  output logic [63:0] mem_lsu_bus_addr_o,
  output logic [1:0]  mem_lsu_bus_size_o,
  output logic [63:0] mem_lsu_bus_data_write_o,
  input  logic        mem_lsu_bus_ready_i,
  input  logic [63:0] mem_lsu_bus_data_read_i,
  input  logic [1:0]  mem_lsu_bus_resp_i
);

  localparam logic [1:0] REQ_READ  = 2'b01;
  localparam logic [1:0] REQ_WRITE = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        we_q, unsigned_q, err_q;
  logic [63:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic        aligned, start, fault, finish, tmo;
  logic [63:0] shifted, load_ext;

  always_comb begin
    unique case (mem_lsu_size_i)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~mem_lsu_addr_i[0];
      2'd2:    aligned = (mem_lsu_addr_i[1:0] == 2'b00);
      default: aligned = (mem_lsu_addr_i[2:0] == 3'b000);
    endcase
  end

`ifdef MEM_LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_hit;

  // Limit is reached on the REQ cycle whose increment would make the count equal TIMEOUT_CYCLES.
  assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)                                           tmo_cnt_q <= '0;
    else if (state_q != REQ)                           tmo_cnt_q <= '0;
    else if (!mem_lsu_bus_ready_i)                     tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
  end
`else
  logic tmo_hit;
  logic unused_timeout;
  assign tmo_hit        = 1'b0;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and completion strobes.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    fault   = 1'b0;
    finish  = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      IDLE: if (mem_lsu_valid_i) begin
        start   = aligned;
        fault   = ~aligned;
        state_d = aligned ? REQ : DONE;
      end
      REQ: begin
        finish = mem_lsu_bus_ready_i;
        tmo    = ~mem_lsu_bus_ready_i & tmo_hit;
        if (finish || tmo) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign shifted = mem_lsu_bus_data_read_i >> {addr_q[2:0], 3'b000};

  always_comb begin
    unique case (size_q)
      2'd0:    load_ext = unsigned_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1:    load_ext = unsigned_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2:    load_ext = unsigned_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (start) begin
        we_q       <= mem_lsu_we_i;
        unsigned_q <= mem_lsu_unsigned_i;
        addr_q     <= mem_lsu_addr_i;
        wdata_q    <= mem_lsu_wdata_i;
        size_q     <= mem_lsu_size_i;
      end
      if (fault || tmo) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end else if (finish) begin
        err_q   <= (mem_lsu_bus_resp_i != 2'b00);
        rdata_q <= (we_q || mem_lsu_bus_resp_i != 2'b00) ? 64'd0 : load_ext;
      end
    end
  end

  assign mem_lsu_stall_o          = (state_q == IDLE && mem_lsu_valid_i) || state_q == REQ;
  assign mem_lsu_done_o           = (state_q == DONE);
  assign mem_lsu_err_o            = err_q;
  assign mem_lsu_rdata_o          = rdata_q;
  assign mem_lsu_bus_valid_o      = (state_q == REQ);
  assign mem_lsu_bus_req_o        = we_q ? REQ_WRITE : REQ_READ;
  assign mem_lsu_bus_addr_o       = addr_q;
  assign mem_lsu_bus_size_o       = size_q;
  assign mem_lsu_bus_data_write_o = wdata_q << {addr_q[2:0], 3'b000};

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: vector table with a completion scoreboard, plus wait-state,
// reset-abort and (when MEM_LSU_TIMEOUT_EN is defined) timeout sequences.
module tb_mem_lsu;
`ifdef MEM_LSU_TIMEOUT_EN
  localparam int unsigned TMO = 4;
`else
  localparam int unsigned TMO = 255;
`endif
  localparam logic [1:0] RD = 2'b01;
  localparam logic [1:0] WR = 2'b10;

  logic clk = 1'b0, rst = 1'b1;
  logic valid = 0, we = 0, uns = 0, ready = 0;
  logic [63:0] addr = 0, wdata = 0, rd = 0;
  logic [1:0] size = 0, resp = 0;
  logic stall, done, err, bus_valid;
  logic [63:0] rdata, bus_addr, bus_wdata;
  logic [1:0] bus_req, bus_size;

  int total = 0, bad = 0;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] rd;
    logic [1:0]  resp;
    logic        mis;
    logic [63:0] exp_bus_wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs[12];

  mem_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .mem_lsu_valid_i(valid), .mem_lsu_we_i(we), .mem_lsu_addr_i(addr),
    .mem_lsu_wdata_i(wdata), .mem_lsu_size_i(size), .mem_lsu_unsigned_i(uns),
    .mem_lsu_stall_o(stall), .mem_lsu_done_o(done), .mem_lsu_err_o(err),
    .mem_lsu_rdata_o(rdata), .mem_lsu_bus_valid_o(bus_valid), .mem_lsu_bus_req_o(bus_req),
    .mem_lsu_bus_addr_o(bus_addr), .mem_lsu_bus_size_o(bus_size),
    .mem_lsu_bus_data_write_o(bus_wdata), .mem_lsu_bus_ready_i(ready),
    .mem_lsu_bus_data_read_i(rd), .mem_lsu_bus_resp_i(resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_sb(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: done_o with no expected completion", name);
    end else begin
      e = sb_q.pop_front();
      check({name, "_err"}, 64'(err), 64'(e.err));
      check({name, "_rdata"}, rdata, e.rdata);
    end
  endtask

  // Issue one access with ready_i high; follow it to completion.
  task automatic run_vec(input vec_t v, input int idx);
    bit seen = 0;
    string tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    valid = 1; we = v.we; addr = v.addr; wdata = v.wdata; size = v.size; uns = v.uns;
    ready = 1; rd = v.rd; resp = v.resp;
    sb_q.push_back('{err: v.exp_err, rdata: v.exp_rdata});
    #1 check({tag, "_stall_idle"}, 64'(stall), 64'd1);
    for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        valid = 0;
        check({tag, "_bus_valid"}, 64'(bus_valid), 64'(!v.mis));
        if (!v.mis) begin
          check({tag, "_bus_req"}, 64'(bus_req), 64'(v.we ? WR : RD));
          check({tag, "_bus_addr"}, bus_addr, v.addr);
          check({tag, "_bus_size"}, 64'(bus_size), 64'(v.size));
          check({tag, "_bus_wdata"}, bus_wdata, v.exp_bus_wdata);
        end
      end
      if (done) begin
        seen = 1;
        check({tag, "_latency"}, 64'(cyc), v.mis ? 64'd1 : 64'd2);
        check({tag, "_stall_done"}, 64'(stall), 64'd0);
        check_sb(tag);
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s_timeout: done_o never seen, expected within 20 cycles", tag);
      void'(sb_q.pop_front());
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_rdata_hold"}, rdata, v.exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    //            we  addr                   wdata                  sz uns rd                     resp mis bus_wdata              rdata                  err
    vecs[0]  = '{0, 64'h0000_0000_0200_BFF8, 64'h0, 2'd3, 0, 64'h0000_0000_0000_1234, 2'd0, 0, 64'h0, 64'h0000_0000_0000_1234, 0};
    vecs[1]  = '{0, 64'h0000_0000_8000_0003, 64'h0, 2'd0, 0, 64'h0000_0000_8000_0000, 2'd0, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 0};
    vecs[2]  = '{0, 64'h0000_0000_8000_0003, 64'h0, 2'd0, 1, 64'h0000_0000_8000_0000, 2'd0, 0, 64'h0, 64'h0000_0000_0000_0080, 0};
    vecs[3]  = '{1, 64'h0000_0000_8000_0004, 64'hDEAD_BEEF, 2'd2, 0, 64'h1111_2222_3333_4444, 2'd0, 0, 64'hDEAD_BEEF_0000_0000, 64'h0, 0};
    vecs[4]  = '{0, 64'h0000_0000_8000_0001, 64'h0, 2'd1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 1, 64'h0, 64'h0, 1};
    vecs[5]  = '{0, 64'h0000_0000_8000_0004, 64'h0, 2'd2, 0, 64'h8765_4321_0000_0000, 2'd0, 0, 64'h0, 64'hFFFF_FFFF_8765_4321, 0};
    vecs[6]  = '{0, 64'h0000_0000_8000_0006, 64'h0, 2'd1, 1, 64'hABCD_0000_0000_0000, 2'd0, 0, 64'h0, 64'h0000_0000_0000_ABCD, 0};
    vecs[7]  = '{0, 64'h0000_0000_8000_0008, 64'h0, 2'd3, 0, 64'h1234_5678_9ABC_DEF0, 2'd1, 0, 64'h0, 64'h0, 1};
    vecs[8]  = '{1, 64'h0000_0000_8000_0007, 64'h5A, 2'd0, 0, 64'h0, 2'd0, 0, 64'h5A00_0000_0000_0000, 64'h0, 0};
    vecs[9]  = '{0, 64'h0000_0000_8000_0002, 64'h0, 2'd2, 0, 64'h0, 2'd0, 1, 64'h0, 64'h0, 1};
    vecs[10] = '{1, 64'h0000_0000_8000_0004, 64'h77, 2'd3, 0, 64'h0, 2'd0, 1, 64'h0, 64'h0, 1};
    vecs[11] = '{0, 64'h0000_0000_8000_0000, 64'h0, 2'd0, 0, 64'hFFFF_FFFF_FFFF_FF7F, 2'd0, 0, 64'h0, 64'h0000_0000_0000_007F, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    check("rst_bus_valid", 64'(bus_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rdata", rdata, 64'd0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Wait states: ready_i low for 3 REQ cycles, then error response.
    @(negedge clk);
    valid = 1; we = 0; addr = 64'h100; size = 2'd2; uns = 0; ready = 0; resp = 2'd0; rd = 64'h0;
    sb_q.push_back('{err: 1'b1, rdata: 64'h0});
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      valid = 0;
      check($sformatf("ws_bus_valid_c%0d", c), 64'(bus_valid), 64'd1);
      check($sformatf("ws_bus_addr_c%0d", c), bus_addr, 64'h100);
      check($sformatf("ws_bus_size_c%0d", c), 64'(bus_size), 64'd2);
      check($sformatf("ws_stall_c%0d", c), 64'(stall), 64'd1);
      check($sformatf("ws_done_c%0d", c), 64'(done), 64'd0);
      if (c == 4) begin ready = 1; resp = 2'd2; end
    end
    @(negedge clk);
    ready = 0; resp = 2'd0;
    check("ws_done", 64'(done), 64'd1);
    if (done) check_sb("ws");
    else void'(sb_q.pop_front());

    // Reset while in REQ abandons the access.
    @(negedge clk);
    valid = 1; we = 0; addr = 64'h200; size = 2'd3; ready = 0;
    @(negedge clk);
    valid = 0;
    check("ra_in_req", 64'(bus_valid), 64'd1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("ra_bus_valid_c%0d", c), 64'(bus_valid), 64'd0);
      check($sformatf("ra_done_c%0d", c), 64'(done), 64'd0);
      check($sformatf("ra_stall_c%0d", c), 64'(stall), 64'd0);
      @(negedge clk);
    end

`ifdef MEM_LSU_TIMEOUT_EN
    // Timeout: ready_i never rises; abort after TMO REQ cycles.
    valid = 1; we = 0; addr = 64'h300; size = 2'd3; ready = 0; rd = 64'h55;
    sb_q.push_back('{err: 1'b1, rdata: 64'h0});
    begin
      bit seen = 0;
      for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
        @(negedge clk);
        valid = 0;
        if (done) begin
          seen = 1;
          check("tmo_latency", 64'(cyc), 64'(TMO + 1));
          check("tmo_bus_valid", 64'(bus_valid), 64'd0);
          check_sb("tmo");
        end
      end
      if (!seen) begin
        total++; bad++;
        $display("FAIL tmo_wait: done_o never seen, expected after %0d cycles", TMO + 1);
        void'(sb_q.pop_front());
      end
    end
    // ready_i on the limit cycle wins: normal completion.
    @(negedge clk);
    valid = 1; we = 0; addr = 64'h308; size = 2'd3; uns = 0; ready = 0; rd = 64'h99; resp = 2'd0;
    sb_q.push_back('{err: 1'b0, rdata: 64'h99});
    for (int c = 1; c <= TMO; c++) begin
      @(negedge clk);
      valid = 0;
      if (c == TMO) ready = 1;
    end
    @(negedge clk);
    ready = 0;
    check("tmo_race_done", 64'(done), 64'd1);
    if (done) check_sb("tmo_race");
    else void'(sb_q.pop_front());
`endif

    @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, meaning bus-wait cycle limit before an access is aborted (used only with MEM_LSU_TIMEOUT_EN).
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: mem_lsu_valid_i  input  1  pipeline MEM stage presents a load/store.
REQ-005 Port: mem_lsu_we_i  input  1  1 = store, 0 = load.
REQ-006 Port: mem_lsu_addr_i  input  64  byte address.
REQ-007 Port: mem_lsu_wdata_i  input  64  store data, right-aligned.
REQ-008 Port: mem_lsu_size_i  input  2  0 = byte, 1 = half, 2 = word, 3 = double.
REQ-009 Port: mem_lsu_unsigned_i  input  1  zero-extend load when 1, sign-extend when 0.
REQ-010 Port: mem_lsu_stall_o  output  1  hold the pipeline.
REQ-011 Port: mem_lsu_done_o  output  1  one-cycle access-complete pulse.
REQ-012 Port: mem_lsu_err_o  output  1  completed access faulted; valid with done_o.
REQ-013 Port: mem_lsu_rdata_o  output  64  extended load result.
REQ-014 Port: mem_lsu_bus_valid_o  output  1  bus request valid.
REQ-015 Port: mem_lsu_bus_req_o  output  2  REQ_READ or REQ_WRITE, encoded per defines.v.
REQ-016 Port: mem_lsu_bus_addr_o  output  64  request address, passed unmodified.
REQ-017 Port: mem_lsu_bus_size_o  output  2  request size.
REQ-018 Port: mem_lsu_bus_data_write_o  output  64  lane-shifted store data.
REQ-019 Port: mem_lsu_bus_ready_i  input  1  responder accepts and completes the request this cycle.
REQ-020 Port: mem_lsu_bus_data_read_i  input  64  read data, valid with ready_i.
REQ-021 Port: mem_lsu_bus_resp_i  input  2  0 = OK; any nonzero value = error.

Function
REQ-022 FSM states: IDLE, REQ, DONE.
REQ-023 IDLE, valid_i=1, aligned: latch we, addr, wdata, size and unsigned; go to REQ.
REQ-024 Aligned means addr[0]=0 for half, addr[1:0]=0 for word, addr[2:0]=0 for double; byte accesses are always aligned.
REQ-025 IDLE, valid_i=1, misaligned: no bus request is issued; go to DONE with err=1 and rdata=0.
REQ-026 REQ: bus_valid_o=1, and all bus outputs are driven from the latched values and stay stable until ready_i is sampled high.
REQ-027 REQ, ready_i=1: capture data_read_i and resp_i; go to DONE; err = (resp_i != 0).
REQ-028 DONE: done_o=1 for exactly one cycle, then go to IDLE; valid_i is ignored while in DONE.
REQ-029 stall_o = (state==IDLE and valid_i) or state==REQ; stall_o is 0 in DONE so the pipeline advances.
REQ-030 Latency with ready_i tied high: valid_i seen at cycle N, bus_valid_o high at N+1, done_o at N+2.
REQ-031 Store data: bus_data_write_o = wdata << (8*addr[2:0]).
REQ-032 Load data: shift data_read_i right by 8*addr[2:0], keep 8/16/32/64 bits per size, then sign- or zero-extend to 64 bits.
REQ-033 rdata_o holds its last value until the next completion; rdata_o = 0 on any error completion or store completion.
REQ-034 bus_req_o = REQ_WRITE when the latched we=1, otherwise REQ_READ.
REQ-035 bus_valid_o = 0 in IDLE and DONE.

Reset
REQ-036 When rst=1 at a clock edge: state <= IDLE, and all registered outputs, latches and the timeout counter <= 0.
REQ-037 Reset asserted in REQ abandons the access: bus_valid_o = 0 from the next cycle, and no done_o is produced.

Configuration
REQ-038 Macro MEM_LSU_TIMEOUT_EN defined: an 8-bit-or-wider counter clears on entry to REQ and increments each REQ cycle while ready_i=0.
REQ-039 With MEM_LSU_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES: go to DONE with err=1 and rdata=0, and drop bus_valid_o.
REQ-040 With MEM_LSU_TIMEOUT_EN, if ready_i=1 in the same cycle the limit is reached, ready_i wins and completion is normal.
REQ-041 Macro MEM_LSU_TIMEOUT_EN undefined: no counter exists, and REQ waits for ready_i indefinitely.

Verification
REQ-042 Load double, addr=0x0200BFF8, ready_i=1, data_read_i=0x0000_0000_0000_1234 -> done_o at N+2, rdata_o=0x1234, err_o=0.
REQ-043 Signed byte load, addr=0x80000003, data_read_i=0x0000_0000_8000_0000 -> rdata_o=0xFFFF_FFFF_FFFF_FF80; with unsigned_i=1 -> rdata_o=0x80.
REQ-044 Word store, addr=0x80000004, wdata=0xDEADBEEF -> bus_data_write_o=0xDEADBEEF_0000_0000, bus_req_o=REQ_WRITE, bus_size_o=2.
REQ-045 Half load at addr=0x80000001 -> bus_valid_o stays 0, done_o=1 with err_o=1 at N+1.
REQ-046 ready_i held low 3 cycles, then resp_i=2 -> bus outputs stable for 4 cycles, stall_o high throughout REQ, done_o with err_o=1.
REQ-047 With MEM_LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, ready_i held low -> err_o=1 after 4 REQ cycles; rst pulsed in REQ -> state returns to IDLE and no done_o is produced.
